// File: rtl/sd_read_server_if.sv
// Client request/data and SD controller signals of sd_read_server.
// slave = the server side, master = clients plus controller.
interface sd_read_server_if;
    logic        req0;
    logic [31:0] addr0;
    logic        accepted0;
    logic        byte_avail0;
    logic        req1;
    logic [31:0] addr1;
    logic        accepted1;
    logic        byte_avail1;
    logic [7:0]  sd_dout;
    logic        ctrl_ready;
    logic        ctrl_rd;
    logic [31:0] ctrl_addr;
    logic        ctrl_byte_available;
    logic [7:0]  ctrl_dout;
    logic        busy;
    logic        err;

    modport slave (
        input  req0, addr0, req1, addr1,
        input  ctrl_ready, ctrl_byte_available, ctrl_dout,
        output accepted0, byte_avail0, accepted1, byte_avail1,
        output sd_dout, ctrl_rd, ctrl_addr, busy, err
    );

    modport master (
        output req0, addr0, req1, addr1,
        output ctrl_ready, ctrl_byte_available, ctrl_dout,
        input  accepted0, byte_avail0, accepted1, byte_avail1,
        input  sd_dout, ctrl_rd, ctrl_addr, busy, err
    );
endinterface

// File: rtl/sd_read_server.sv
// Two-client round-robin SD block-read server (client 0 bgm, client 1 sfx).
// Define SD_TIMEOUT_EN to add the per-byte watchdog and sticky err flag.
module sd_read_server #(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk_in,
    input  logic             reset_in,
    sd_read_server_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;

    localparam int CW = $clog2(BLOCK_BYTES) + 1;
    localparam logic [CW-1:0] FULL = CW'(BLOCK_BYTES);

    state_t          state_q, state_d;
    logic            win_q, win_d;
    logic            last_q, last_d;
    logic [31:0]     addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            acc0_q, acc0_d;
    logic            acc1_q, acc1_d;
    logic            ba0_q, ba0_d;
    logic            ba1_q, ba1_d;
    logic [7:0]      dout_q, dout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            pick1;
    logic            unused_addr;

`ifdef SD_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // Only 23 bits of block index survive the shift into a byte address.
    assign unused_addr = ^{bus.addr0[31:23], bus.addr1[31:23]};

    // Both requesting: the client not served last time wins.
    assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        acc0_d  = 1'b0;
        acc1_d  = 1'b0;
        ba0_d   = 1'b0;
        ba1_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    win_d   = pick1;
                    addr_d  = pick1 ? {bus.addr1[22:0], 9'b0}
                                    : {bus.addr0[22:0], 9'b0};
                    rd_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.ctrl_ready) begin
                    rd_d    = 1'b0;
                    acc0_d  = ~win_q;
                    acc1_d  = win_q;
                    cnt_d   = '0;
                    last_d  = win_q;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (cnt_q == FULL) begin
                    state_d = DONE;
                end else if (bus.ctrl_byte_available) begin
                    dout_d = bus.ctrl_dout;
                    ba0_d  = ~win_q;
                    ba1_d  = win_q;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.ctrl_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SD_TIMEOUT_EN
        err_d = err_q;
        wd_d  = '0;
        if (state_q == ISSUE || state_q == STREAM) begin
            if (bus.ctrl_byte_available) begin
                wd_d = '0;
            end else if (wd_q == WD_LAST) begin
                err_d   = 1'b1;
                rd_d    = 1'b0;
                acc0_d  = 1'b0;
                acc1_d  = 1'b0;
                ba0_d   = 1'b0;
                ba1_d   = 1'b0;
                state_d = DONE;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            acc0_q  <= 1'b0;
            acc1_q  <= 1'b0;
            ba0_q   <= 1'b0;
            ba1_q   <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef SD_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            ba0_q   <= ba0_d;
            ba1_q   <= ba1_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`ifdef SD_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.accepted0   = acc0_q;
    assign bus.accepted1   = acc1_q;
    assign bus.byte_avail0 = ba0_q;
    assign bus.byte_avail1 = ba1_q;
    assign bus.sd_dout     = dout_q;
    assign bus.ctrl_rd     = rd_q;
    assign bus.ctrl_addr   = addr_q;
    assign bus.busy        = busy_q;
`ifdef SD_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: doc/sd_read_server.md
Name: sd_read_server

Overview:
- Responder end of the SD block-read request protocol that the audio blocks drive (request_sd_read / sd_addr in; sd_read_accepted / sd_byte_available / sd_dout out).
- Arbitrates two requesters: client 0 is the bgm path, client 1 is the sfx path.
- Each accepted request is converted into one 512-byte block read on the SD controller, and the bytes are forwarded to the winning client.
- Sits between the audio FIFOs' sd_to_fifo loaders and the SD controller.

Parameters:
- BLOCK_BYTES, 512, bytes per block read; must be a power of two.
- TIMEOUT_CYCLES, 1000000, cycles without a byte before a read is aborted (used only with SD_TIMEOUT_EN).

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  reset; asynchronous, active-high
- req0  in  1  client 0 read request (level)
- addr0  in  32  client 0 block index
- accepted0  out  1  one-cycle pulse: client 0 request taken
- byte_avail0  out  1  one-cycle pulse: sd_dout valid for client 0
- req1  in  1  client 1 read request (level)
- addr1  in  32  client 1 block index
- accepted1  out  1  one-cycle pulse: client 1 request taken
- byte_avail1  out  1  one-cycle pulse: sd_dout valid for client 1
- sd_dout  out  8  forwarded data byte (shared by both clients)
- ctrl_ready  in  1  SD controller idle/ready
- ctrl_rd  out  1  read strobe to controller
- ctrl_addr  out  32  byte address to controller (block index << 9)
- ctrl_byte_available  in  1  controller per-byte pulse
- ctrl_dout  in  8  controller data byte
- busy  out  1  high in every state except IDLE
- err  out  1  sticky read-timeout flag

Behaviour:
- Reset (async, reset_in=1):
  - All outputs 0, state IDLE, byte counter 0.
  - Round-robin pointer set so client 0 has priority first.
  - A reset mid-read abandons the transfer immediately; no further byte pulses occur.
- IDLE:
  - If req0 or req1 is high, pick the winner: if only one is requesting, it wins; if both, the non-last-served client wins.
  - Latch the winner and its addr into ctrl_addr as {addr[22:0],9'b0}. Go to ISSUE.
- ISSUE:
  - ctrl_rd=1 while ctrl_ready=1.
  - On the first cycle ctrl_ready=0, drive ctrl_rd=0 and pulse acceptedN for one cycle.
  - Clear the byte counter, update the round-robin pointer, go to STREAM.
- STREAM:
  - Each ctrl_byte_available pulse registers ctrl_dout into sd_dout and pulses byte_availN on the next cycle (latency 1 clk).
  - The byte counter increments per pulse.
  - When the counter reaches BLOCK_BYTES, go to DONE.
  - Pulses arriving while the counter is at BLOCK_BYTES are ignored.
- DONE:
  - Wait for ctrl_ready=1, then go to IDLE.
  - A new grant is possible on the following cycle.
- Other rules:
  - sd_dout holds its last value between pulses.
  - byte_avail of the non-winning client is never asserted.
  - Clients must drop req on or before their accepted pulse. A req still high when the block returns to IDLE is treated as a new request.
  - addr/req changes during ISSUE/STREAM/DONE have no effect.
  - Address wrap: addr bits above 22 are dropped; no error is raised.
  - busy=0 only in IDLE.

Optional Feature:
- SD_TIMEOUT_EN defined:
  - A watchdog counts cycles in ISSUE and STREAM since the last ctrl_byte_available (or since entry).
  - At TIMEOUT_CYCLES: set err (sticky until reset), drop ctrl_rd, go to DONE.
  - The client receives no further byte pulses.
- Undefined: no watchdog logic; err tied to 0.

Test Plan:
- req0=1, addr0=8200, ctrl model supplies 512 bytes 0..255,0..255 -> ctrl_addr=4198400; accepted0 pulses once; 512 byte_avail0 pulses each 1 clk after the ctrl pulse; sd_dout matches; byte_avail1 stays 0; busy falls after ctrl_ready returns.
- req0 and req1 both high in the same cycle after reset -> client 0 served first, then client 1; next simultaneous pair -> client 0 again (strict alternation).
- req1 raised during a client 0 STREAM -> no accepted1 until client 0's 512 bytes and DONE complete; then accepted1 fires.
- reset_in asserted after byte 100 of a read -> all outputs 0 within the same cycle (async); no byte pulses after release; a fresh request completes normally.
- Extra 513th ctrl_byte_available pulse injected -> ignored; exactly 512 client pulses.
- SD_TIMEOUT_EN with TIMEOUT_CYCLES=50, controller stalls after byte 10 -> err=1 at 50 cycles after byte 10; state goes to DONE then IDLE; err stays 1 until reset.
